// File: rtl/frontier_buffer_pkg.sv
// Shared types and default sizing for the active-vertex frontier buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: lane entry struct, lane end-state enum, default widths/depths.
// Defaults mirror the build-wide accelerator sizing.
package frontier_buffer_pkg;

    localparam int V_ID_WIDTH_DEF = 32;
    localparam int CORE_NUM_DEF   = 4;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int AF_MARGIN_DEF  = 2;

    // id field is sized to the build-wide vertex id width; lanes narrower
    // than that zero-extend on write and truncate on read.
    typedef struct packed {
        logic [V_ID_WIDTH_DEF-1:0] id;
        logic                      updated;
        logic                      pull_first_flag;
    } active_v_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        EMIT    = 2'd2
    } end_state_e;

endpackage

// File: rtl/frontier_lane.sv
// One frontier lane: vertex FIFO, iteration-end ordering FSM, registered outputs.
// Latency: vertex 1 cycle after the push edge when empty; end pulse 1 cycle after the last vertex leaves.
// Backpressure: pops stall while next_stage_full; buffer_full warns early; a push into a full FIFO without a pop is dropped and sets sticky overflow.
// Ports: push_* / end_* from upstream, next_stage_full from downstream, out_* / iteration_end* registered to downstream.
module frontier_lane
    import frontier_buffer_pkg::*;
#(
    parameter int V_ID_WIDTH = V_ID_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AF_MARGIN  = AF_MARGIN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [V_ID_WIDTH-1:0] push_id,
    input  logic                  push_updated,
    input  logic                  push_pull_first_flag,
    input  logic                  push_vld,
    input  logic                  end_flag,
    input  logic                  end_vld,
    input  logic                  next_stage_full,
    output logic                  buffer_full,
    output logic                  overflow,
    output logic [V_ID_WIDTH-1:0] out_id,
    output logic                  out_updated,
    output logic                  out_pull_first_flag,
    output logic                  out_vld,
    output logic                  iteration_end,
    output logic                  iteration_end_valid
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    active_v_entry_t   mem_q [FIFO_DEPTH];
    active_v_entry_t   wr_entry;
    active_v_entry_t   out_entry_q, out_entry_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              out_vld_q, out_vld_d;
    logic              fwd_q, fwd_d;
    end_state_e        state_q, state_d;
    logic              pop, full, accept;

    // FIFO bookkeeping; a pop frees a slot in the same cycle so a push at full is still accepted.
    always_comb begin
        wr_entry                 = '0;
        wr_entry.id              = V_ID_WIDTH_DEF'(push_id);
        wr_entry.updated         = push_updated;
        wr_entry.pull_first_flag = push_pull_first_flag;

        pop         = (count_q != '0) && !next_stage_full;
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        accept      = push_vld && (!full || pop);
        wr_ptr_d    = wr_ptr_q + PTR_W'(accept);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q + CNT_W'(accept) - CNT_W'(pop);
        overflow_d  = overflow_q | (push_vld & ~accept);
        out_entry_d = pop ? mem_q[rd_ptr_q] : out_entry_q;
        out_vld_d   = pop;
    end

    // Storage is not reset: a cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_entry_q <= '0;
            out_vld_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_entry_q <= out_entry_d;
            out_vld_q   <= out_vld_d;
        end
    end

    // End FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fwd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fwd_q   <= fwd_d;
        end
    end

    // End FSM next state. PENDING waits for a fully quiet, empty lane so the
    // pulse always follows the last vertex output. Markers in PENDING are absorbed;
    // a new end arriving during the EMIT cycle is kept rather than lost.
    always_comb begin
        state_d = state_q;
        fwd_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (end_vld && end_flag) begin
                    state_d = PENDING;
                end else if (end_vld) begin
                    fwd_d = 1'b1;
                end
            end
            PENDING: begin
                if ((count_q == '0) && !push_vld && !pop) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                state_d = (end_vld && end_flag) ? PENDING : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // End FSM outputs; fwd_q carries a (0,1) marker seen in IDLE.
    always_comb begin
        iteration_end       = (state_q == EMIT);
        iteration_end_valid = (state_q == EMIT) | fwd_q;
    end

    assign buffer_full         = (count_q >= CNT_W'(FIFO_DEPTH - AF_MARGIN));
    assign overflow            = overflow_q;
    assign out_id              = V_ID_WIDTH'(out_entry_q.id);
    assign out_updated         = out_entry_q.updated;
    assign out_pull_first_flag = out_entry_q.pull_first_flag;
    assign out_vld             = out_vld_q;

endmodule

// File: rtl/active_vertex_frontier_buffer.sv
// Per-core frontier buffer between the iteration-end stage and the next stage.
// Latency: vertex 1 cycle after its push edge when empty; iteration end re-emitted only after the lane drains.
// Backpressure: next_stage_full stalls each lane independently; buffer_full is almost-full to upstream; overflow is sticky.
// Ports: front_* inputs and active_v_* / iteration_end* outputs are CORE_NUM lanes packed side by side,
//        lane i at [i*V_ID_WIDTH +: V_ID_WIDTH] for ids and bit i for 1-bit signals; rst[i] resets lane i only.
module active_vertex_frontier_buffer
    import frontier_buffer_pkg::*;
#(
    parameter int V_ID_WIDTH = V_ID_WIDTH_DEF,
    parameter int CORE_NUM   = CORE_NUM_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AF_MARGIN  = AF_MARGIN_DEF
) (
    input  logic                           clk,
    input  logic [CORE_NUM-1:0]            rst,
    input  logic [CORE_NUM*V_ID_WIDTH-1:0] front_active_v_id,
    input  logic [CORE_NUM-1:0]            front_active_v_updated,
    input  logic [CORE_NUM-1:0]            front_active_v_pull_first_flag,
    input  logic [CORE_NUM-1:0]            front_active_v_valid,
    input  logic [CORE_NUM-1:0]            front_iteration_end,
    input  logic [CORE_NUM-1:0]            front_iteration_end_valid,
    input  logic [CORE_NUM-1:0]            next_stage_full,
    output logic [CORE_NUM-1:0]            buffer_full,
    output logic [CORE_NUM-1:0]            overflow,
    output logic [CORE_NUM*V_ID_WIDTH-1:0] active_v_id,
    output logic [CORE_NUM-1:0]            active_v_updated,
    output logic [CORE_NUM-1:0]            active_v_pull_first_flag,
    output logic [CORE_NUM-1:0]            active_v_valid,
    output logic [CORE_NUM-1:0]            iteration_end,
    output logic [CORE_NUM-1:0]            iteration_end_valid
);
    for (genvar i = 0; i < CORE_NUM; i++) begin : g_lane
        frontier_lane #(
            .V_ID_WIDTH (V_ID_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .AF_MARGIN  (AF_MARGIN)
        ) u_lane (
            .clk                 (clk),
            .rst                 (rst[i]),
            .push_id             (front_active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]),
            .push_updated        (front_active_v_updated[i]),
            .push_pull_first_flag(front_active_v_pull_first_flag[i]),
            .push_vld            (front_active_v_valid[i]),
            .end_flag            (front_iteration_end[i]),
            .end_vld             (front_iteration_end_valid[i]),
            .next_stage_full     (next_stage_full[i]),
            .buffer_full         (buffer_full[i]),
            .overflow            (overflow[i]),
            .out_id              (active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]),
            .out_updated         (active_v_updated[i]),
            .out_pull_first_flag (active_v_pull_first_flag[i]),
            .out_vld             (active_v_valid[i]),
            .iteration_end       (iteration_end[i]),
            .iteration_end_valid (iteration_end_valid[i])
        );
    end

endmodule

// File: tb/tb_active_vertex_frontier_buffer.sv
// Scoreboard bench for active_vertex_frontier_buffer: directed stimulus pushes
// expected outputs per lane; a negedge monitor pops and compares in order.
module tb_active_vertex_frontier_buffer;
    localparam int NC    = 4;
    localparam int VW    = 32;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;

    logic              clk = 1'b0;
    logic [NC-1:0]     rst;
    logic [NC*VW-1:0]  f_id;
    logic [NC-1:0]     f_upd, f_pf, f_vld, f_end, f_endv, nsf;
    logic [NC-1:0]     buffer_full, overflow;
    logic [NC*VW-1:0]  a_id;
    logic [NC-1:0]     a_upd, a_pf, a_vld, ie, iev;

    active_vertex_frontier_buffer #(
        .V_ID_WIDTH(VW), .CORE_NUM(NC), .FIFO_DEPTH(DEPTH), .AF_MARGIN(AFM)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .front_active_v_id             (f_id),
        .front_active_v_updated        (f_upd),
        .front_active_v_pull_first_flag(f_pf),
        .front_active_v_valid          (f_vld),
        .front_iteration_end           (f_end),
        .front_iteration_end_valid     (f_endv),
        .next_stage_full               (nsf),
        .buffer_full                   (buffer_full),
        .overflow                      (overflow),
        .active_v_id                   (a_id),
        .active_v_updated              (a_upd),
        .active_v_pull_first_flag      (a_pf),
        .active_v_valid                (a_vld),
        .iteration_end                 (ie),
        .iteration_end_valid           (iev)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          lane;
        bit          is_end;
        logic [VW-1:0] id;
        bit          upd;
        bit          pf;
        bit          endf;
        int          at;     // expected cycle, -1 when only order matters
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;

    function automatic int find_lane(int lane);
        for (int k = 0; k < sb.size(); k++)
            if (sb[k].lane == lane) return k;
        return -1;
    endfunction

    task automatic exp_v(int lane, logic [VW-1:0] id, bit u, bit p, int at);
        ev_t e;
        e.lane = lane; e.is_end = 1'b0; e.id = id; e.upd = u; e.pf = p; e.endf = 1'b0; e.at = at;
        sb.push_back(e);
    endtask

    task automatic exp_e(int lane, bit endf, int at);
        ev_t e;
        e.lane = lane; e.is_end = 1'b1; e.id = '0; e.upd = 1'b0; e.pf = 1'b0; e.endf = endf; e.at = at;
        sb.push_back(e);
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every presented output must match the head of its lane's queue.
    initial begin
        int  idx;
        ev_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (a_vld[i] === 1'b1) begin
                    total++;
                    idx = find_lane(i);
                    if (idx < 0) begin
                        bad++;
                        $display("FAIL unexpected_vertex lane %0d: got id=%0h at cyc %0d, want nothing",
                                 i, a_id[i*VW +: VW], cyc);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        if (e.is_end || a_id[i*VW +: VW] !== e.id || a_upd[i] !== e.upd ||
                            a_pf[i] !== e.pf || (e.at >= 0 && cyc != e.at)) begin
                            bad++;
                            $display("FAIL vertex lane %0d: got id=%0h upd=%0b pf=%0b cyc=%0d, want is_end=%0b id=%0h upd=%0b pf=%0b cyc=%0d",
                                     i, a_id[i*VW +: VW], a_upd[i], a_pf[i], cyc, e.is_end, e.id, e.upd, e.pf, e.at);
                        end
                    end
                end
                if (iev[i] === 1'b1) begin
                    total++;
                    idx = find_lane(i);
                    if (idx < 0) begin
                        bad++;
                        $display("FAIL unexpected_end lane %0d: got end=%0b at cyc %0d, want nothing", i, ie[i], cyc);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        if (!e.is_end || ie[i] !== e.endf || (e.at >= 0 && cyc != e.at)) begin
                            bad++;
                            $display("FAIL end lane %0d: got end=%0b cyc=%0d, want is_end=%0b end=%0b cyc=%0d",
                                     i, ie[i], cyc, e.is_end, e.endf, e.at);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr();
        f_vld  = '0;
        f_endv = '0;
        f_end  = '0;
    endtask

    task automatic drive(int lane, logic [VW-1:0] id, bit u, bit p);
        f_id[lane*VW +: VW] = id;
        f_upd[lane] = u;
        f_pf[lane]  = p;
        f_vld[lane] = 1'b1;
    endtask

    initial begin
        int c0;
        bit u, p;
        rst = '1; f_id = '0; f_upd = '0; f_pf = '0; nsf = '0;
        clr();

        // Reset
        repeat (10) tick();
        rst = '0;
        tick();
        chk("reset_id",   64'(a_id), 64'd0);
        chk("reset_upd",  64'(a_upd), 64'd0);
        chk("reset_pf",   64'(a_pf), 64'd0);
        chk("reset_vld",  64'(a_vld), 64'd0);
        chk("reset_ie",   64'(ie), 64'd0);
        chk("reset_iev",  64'(iev), 64'd0);
        chk("reset_bfull", 64'(buffer_full), 64'd0);
        chk("reset_ovf",  64'(overflow), 64'd0);

        // Passthrough on all lanes: output one cycle after the push edge, single cycle.
        c0 = cyc;
        for (int i = 0; i < NC; i++) begin
            drive(i, VW'(i), 1'b1, 1'b1);
            exp_v(i, VW'(i), 1'b1, 1'b1, c0 + 2);
        end
        tick(); clr();
        tick();
        tick();
        chk("pass_vld_drops", 64'(a_vld), 64'd0);

        // Backpressure lane 0: ids 1..5 come out on consecutive cycles after release.
        nsf[0] = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 5; k++) begin
            u = (k % 2) == 1;
            p = ((k / 2) % 2) == 1;
            drive(0, VW'(k), u, p);
            exp_v(0, VW'(k), u, p, c0 + 5 + k);
            tick();
        end
        clr();
        nsf[0] = 1'b0;
        repeat (8) tick();

        // Overflow lane 1: 17 pushes stalled, first 16 drain in order.
        nsf[1] = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 17; k++) begin
            u = (k % 3) == 0;
            p = (k % 2) == 1;
            drive(1, VW'(32'h100 + k), u, p);
            if (k < 16) exp_v(1, VW'(32'h100 + k), u, p, c0 + 18 + k);
            tick();
            if (k == 12) chk("bfull_at_13", 64'(buffer_full[1]), 64'd0);
            if (k == 13) chk("bfull_at_14", 64'(buffer_full[1]), 64'd1);
            if (k == 15) chk("ovf_before_drop", 64'(overflow[1]), 64'd0);
        end
        clr();
        chk("ovf_after_drop", 64'(overflow[1]), 64'd1);
        nsf[1] = 1'b0;
        repeat (20) tick();
        chk("ovf_sticky", 64'(overflow[1]), 64'd1);
        chk("bfull_drained", 64'(buffer_full[1]), 64'd0);

        // End ordering lane 2: 7, then 8 with end in the same cycle, while stalled.
        nsf[2] = 1'b1;
        c0 = cyc;
        drive(2, VW'(7), 1'b1, 1'b0);
        exp_v(2, VW'(7), 1'b1, 1'b0, c0 + 3);
        tick();
        drive(2, VW'(8), 1'b0, 1'b1);
        f_end[2] = 1'b1; f_endv[2] = 1'b1;
        exp_v(2, VW'(8), 1'b0, 1'b1, c0 + 4);
        exp_e(2, 1'b1, c0 + 5);
        tick(); clr();
        nsf[2] = 1'b0;
        repeat (6) tick();

        // End on empty lane 3: pulse one cycle after the sampling edge.
        c0 = cyc;
        f_end[3] = 1'b1; f_endv[3] = 1'b1;
        exp_e(3, 1'b1, c0 + 2);
        tick(); clr();
        repeat (4) tick();

        // (0,1) marker in IDLE is forwarded unchanged.
        f_end[3] = 1'b0; f_endv[3] = 1'b1;
        exp_e(3, 1'b0, -1);
        tick(); clr();
        repeat (3) tick();

        // Second end while PENDING is absorbed: one vertex, one pulse.
        nsf[3] = 1'b1;
        c0 = cyc;
        drive(3, VW'(32'h33), 1'b1, 1'b1);
        f_end[3] = 1'b1; f_endv[3] = 1'b1;
        exp_v(3, VW'(32'h33), 1'b1, 1'b1, c0 + 4);
        exp_e(3, 1'b1, c0 + 5);
        tick(); clr();
        f_end[3] = 1'b1; f_endv[3] = 1'b1;
        tick(); clr();
        tick();
        nsf[3] = 1'b0;
        repeat (6) tick();

        // Lane reset: lane 0 holds 3 entries and a pending end; lane 1 keeps flowing.
        nsf[0] = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(0, VW'(32'h90 + k), 1'b1, 1'b0);
            else f_vld[0] = 1'b0;
            if (k == 2) begin f_end[0] = 1'b1; f_endv[0] = 1'b1; end
            else begin f_end[0] = 1'b0; f_endv[0] = 1'b0; end
            if (k == 3) begin
                rst[0] = 1'b1;
                #1;
                chk("lane_rst_async_id", 64'(a_id[0 +: VW]), 64'd0);
            end
            drive(1, VW'(32'h200 + k), 1'b0, 1'b1);
            exp_v(1, VW'(32'h200 + k), 1'b0, 1'b1, c0 + 2 + k);
            tick();
        end
        chk("lane_rst_vld", 64'(a_vld[0]), 64'd0);
        chk("lane_rst_iev", 64'(iev[0]), 64'd0);
        chk("lane_rst_bfull", 64'(buffer_full[0]), 64'd0);
        chk("lane1_ovf_kept", 64'(overflow[1]), 64'd1);
        clr();
        rst[0] = 1'b0;
        nsf[0] = 1'b0;
        repeat (10) tick();
        c0 = cyc;
        drive(0, VW'(32'h55), 1'b0, 1'b0);
        exp_v(0, VW'(32'h55), 1'b0, 1'b0, c0 + 2);
        tick(); clr();
        repeat (4) tick();

        // Drain check with a bounded wait.
        for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
